// File: rtl/uart_pkg.sv
// UART transmitter shared definitions.
// FSM encoding, default oversampling and data-length helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int UBRR_W         = 12;
    localparam int DATA_W         = 8;

    localparam int DATA_LEN_5 = 5;
    localparam int DATA_LEN_6 = 6;
    localparam int DATA_LEN_7 = 7;
    localparam int DATA_LEN_8 = 8;

    // Number of data bits selected by a DLS code.
    function automatic int data_len(input logic [1:0] dls);
        int len;
        unique case (dls)
            2'd0:    len = DATA_LEN_5;
            2'd1:    len = DATA_LEN_6;
            2'd2:    len = DATA_LEN_7;
            default: len = DATA_LEN_8;
        endcase
        return len;
    endfunction

    // Index of the last data bit sent for a DLS code.
    function automatic logic [2:0] last_index(input logic [1:0] dls);
        return 3'(data_len(dls) - 1);
    endfunction

    // Parity over the sent data bits; eps=1 even, eps=0 odd.
    function automatic logic parity(
        input logic [DATA_W-1:0] data,
        input logic [1:0]        dls,
        input logic              eps
    );
        logic p;
        p = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < data_len(dls)) begin
                p = p ^ data[i];
            end
        end
        return p ^ ~eps;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud prescaler for the UART transmitter.
// Emits a one-cycle tick every div+1 clocks; clr restarts the count.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [UBRR_W-1:0] div,
    output logic              tick
);

    logic [UBRR_W-1:0] cnt_q;
    logic              wrap;

    assign wrap = (cnt_q == div);

    // Prescale counter, held at zero while cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = !clr && wrap;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with configurable length, parity and stop bits.
// Frame settings are captured at acceptance and held for the frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              TxStart,
    input  logic [DATA_W-1:0] TxData,
    input  logic [UBRR_W-1:0] UBRR,
    input  logic [1:0]        DLS,
    input  logic              STOP,
    input  logic              PEN,
    input  logic              EPS,
    output logic              Tx,
    output logic              TxBusy,
    output logic              TxDone
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TLAST = TW'(OVERSAMPLE - 1);

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] data_q;
    logic [UBRR_W-1:0] ubrr_q;
    logic [1:0]        dls_q;
    logic              stop_q;
    logic              pen_q;
    logic              eps_q;
    logic [2:0]        idx_q;
    logic [TW-1:0]     tcnt_q;
    logic              done_q;

    logic accept;
    logic tick;
    logic bit_end;
    logic done_d;
    logic tx_c;

    assign accept  = (state_q == IDLE) && TxStart;
    assign bit_end = tick && (tcnt_q == TLAST);

    uart_baud_gen u_baud (
        .clk  (pClk),
        .rst  (pReset),
        .clr  (state_q == IDLE),
        .div  (ubrr_q),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, line level and completion decode.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        tx_c    = 1'b1;
        unique case (state_q)
            IDLE: begin
                tx_c = 1'b1;
                if (TxStart) begin
                    state_d = START;
                end
            end
            START: begin
                tx_c = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_c = data_q[idx_q];
                if (bit_end && idx_q == last_index(dls_q)) begin
                    state_d = pen_q ? PARITY : STOP1;
                end
            end
            PARITY: begin
                tx_c = parity(data_q, dls_q, eps_q);
                if (bit_end) begin
                    state_d = STOP1;
                end
            end
            STOP1: begin
                tx_c = 1'b1;
                if (bit_end) begin
                    state_d = stop_q ? STOP2 : IDLE;
                    done_d  = !stop_q;
                end
            end
            STOP2: begin
                tx_c = 1'b1;
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_c    = 1'b1;
            end
        endcase
    end

    // Frame settings captured when a request is accepted.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            data_q <= '0;
            ubrr_q <= '0;
            dls_q  <= '0;
            stop_q <= 1'b0;
            pen_q  <= 1'b0;
            eps_q  <= 1'b0;
        end else if (accept) begin
            data_q <= TxData;
            ubrr_q <= UBRR;
            dls_q  <= DLS;
            stop_q <= STOP;
            pen_q  <= PEN;
            eps_q  <= EPS;
        end
    end

    // Baud ticks per bit and the data-bit index.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            tcnt_q <= '0;
            idx_q  <= '0;
        end else if (state_q == IDLE) begin
            tcnt_q <= '0;
            idx_q  <= '0;
        end else begin
            if (tick) begin
                tcnt_q <= (tcnt_q == TLAST) ? '0 : tcnt_q + 1'b1;
            end
            if (state_q == DATA && bit_end) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // One-cycle completion pulse in the first idle cycle.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign Tx     = tx_c;
    assign TxBusy = (state_q != IDLE);
    assign TxDone = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx.
// Directed scenarios plus randomized frames against a frame model.
module tb_uart_tx;

    typedef struct {
        logic [7:0]  data;
        logic [11:0] ubrr;
        logic [1:0]  dls;
        logic        stop;
        logic        pen;
        logic        eps;
    } cfg_t;

    logic        pClk = 1'b0;
    logic        pReset = 1'b1;
    logic        TxStart = 1'b0;
    logic [7:0]  TxData = '0;
    logic [11:0] UBRR = '0;
    logic [1:0]  DLS = '0;
    logic        STOP = 1'b0;
    logic        PEN = 1'b0;
    logic        EPS = 1'b0;
    logic        Tx;
    logic        TxBusy;
    logic        TxDone;

    int tests = 0;
    int failed = 0;

    uart_tx #(.OVERSAMPLE(16)) dut (
        .pClk    (pClk),
        .pReset  (pReset),
        .TxStart (TxStart),
        .TxData  (TxData),
        .UBRR    (UBRR),
        .DLS     (DLS),
        .STOP    (STOP),
        .PEN     (PEN),
        .EPS     (EPS),
        .Tx      (Tx),
        .TxBusy  (TxBusy),
        .TxDone  (TxDone)
    );

    always #5 pClk = ~pClk;

    function automatic int flen(input cfg_t c);
        return 1 + 5 + int'(c.dls) + int'(c.pen) + 1 + int'(c.stop);
    endfunction

    // Expected serial bits; element k is the k-th bit on the line.
    function automatic logic [11:0] model(input cfg_t c);
        logic [11:0] s;
        int n;
        int k;
        logic p;
        s = '1;
        n = 5 + int'(c.dls);
        s[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            s[1 + i] = c.data[i];
            p = p ^ c.data[i];
        end
        k = 1 + n;
        if (c.pen) begin
            s[k] = c.eps ? p : ~p;
        end
        return s;
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.data = 8'($urandom);
        c.ubrr = 12'($urandom_range(0, 3));
        c.dls  = 2'($urandom_range(0, 3));
        c.stop = 1'($urandom_range(0, 1));
        c.pen  = 1'($urandom_range(0, 1));
        c.eps  = 1'($urandom_range(0, 1));
        return c;
    endfunction

    task automatic drive(input cfg_t c);
        TxData = c.data;
        UBRR   = c.ubrr;
        DLS    = c.dls;
        STOP   = c.stop;
        PEN    = c.pen;
        EPS    = c.eps;
    endtask

    task automatic run_frame(
        input cfg_t        c,
        input logic [11:0] seq,
        input bit          started,
        input bit          disturb,
        input bit          chain,
        input cfg_t        nxt,
        input string       name
    );
        int n;
        int bc;
        bit bad;
        logic atx;
        logic abusy;
        logic adone;
        n  = flen(c);
        bc = (int'(c.ubrr) + 1) * 16;
        if (!started) begin
            @(negedge pClk);
            drive(c);
            TxStart = 1'b1;
        end
        for (int k = 0; k < n; k++) begin
            bad = 1'b0;
            atx = 1'b0;
            abusy = 1'b0;
            adone = 1'b0;
            for (int j = 0; j < bc; j++) begin
                @(negedge pClk);
                TxStart = 1'b0;
                if (disturb && k == 2 && j == 3) begin
                    TxStart = 1'b1;
                    UBRR    = 12'd5;
                    TxData  = ~TxData;
                    DLS     = ~DLS;
                end
                if (!bad && (Tx !== seq[k] || TxBusy !== 1'b1
                             || TxDone !== 1'b0)) begin
                    bad = 1'b1;
                    atx = Tx;
                    abusy = TxBusy;
                    adone = TxDone;
                end
            end
            tests++;
            if (bad) begin
                failed++;
                $display("FAIL %s bit%0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                         name, k, atx, abusy, adone, seq[k]);
            end
        end
        @(negedge pClk);
        TxStart = 1'b0;
        tests++;
        if (TxDone !== 1'b1 || TxBusy !== 1'b0 || Tx !== 1'b1) begin
            failed++;
            $display("FAIL %s done: done=%b busy=%b tx=%b, want 1 0 1",
                     name, TxDone, TxBusy, Tx);
        end
        if (chain) begin
            drive(nxt);
            TxStart = 1'b1;
        end else begin
            @(negedge pClk);
            tests++;
            if (TxDone !== 1'b0) begin
                failed++;
                $display("FAIL %s done_pulse: done=%b, want 0", name, TxDone);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pClk);
        tests++;
        if (Tx !== 1'b1 || TxBusy !== 1'b0 || TxDone !== 1'b0) begin
            failed++;
            $display("FAIL reset: tx=%b busy=%b done=%b, want 1 0 0",
                     Tx, TxBusy, TxDone);
        end
        pReset = 1'b0;
        repeat (2) @(negedge pClk);
        tests++;
        if (Tx !== 1'b1 || TxBusy !== 1'b0 || TxDone !== 1'b0) begin
            failed++;
            $display("FAIL idle: tx=%b busy=%b done=%b, want 1 0 0",
                     Tx, TxBusy, TxDone);
        end
    endtask

    task automatic test_frame_a5();
        cfg_t c;
        c = '{data: 8'hA5, ubrr: 12'd0, dls: 2'd3,
              stop: 1'b0, pen: 1'b0, eps: 1'b0};
        run_frame(c, {2'b11, 10'b1101001010}, 1'b0, 1'b0, 1'b0, c, "a5");
    endtask

    task automatic test_parity();
        cfg_t c;
        c = '{data: 8'h13, ubrr: 12'd0, dls: 2'd0,
              stop: 1'b1, pen: 1'b1, eps: 1'b1};
        run_frame(c, {3'b111, 9'b111100110}, 1'b0, 1'b0, 1'b0, c, "even");
        c.eps = 1'b0;
        run_frame(c, {3'b111, 9'b110100110}, 1'b0, 1'b0, 1'b0, c, "odd");
    endtask

    task automatic test_ignore_midframe();
        cfg_t c;
        bit bad;
        c = '{data: 8'h5A, ubrr: 12'd0, dls: 2'd3,
              stop: 1'b0, pen: 1'b1, eps: 1'b0};
        run_frame(c, model(c), 1'b0, 1'b1, 1'b0, c, "ignore");
        bad = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge pClk);
            if (Tx !== 1'b1 || TxBusy !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            failed++;
            $display("FAIL no_requeue: tx=%b busy=%b, want 1 0", Tx, TxBusy);
        end
    endtask

    task automatic test_back_to_back();
        cfg_t a;
        cfg_t b;
        a = '{data: 8'h81, ubrr: 12'd0, dls: 2'd3,
              stop: 1'b0, pen: 1'b1, eps: 1'b1};
        b = '{data: 8'h3C, ubrr: 12'd0, dls: 2'd3,
              stop: 1'b0, pen: 1'b0, eps: 1'b0};
        run_frame(a, model(a), 1'b0, 1'b0, 1'b1, b, "b2b_first");
        run_frame(b, model(b), 1'b1, 1'b0, 1'b0, b, "b2b_second");
    endtask

    task automatic test_reset_midframe();
        cfg_t c;
        cfg_t d;
        bit bad;
        c = '{data: 8'h00, ubrr: 12'd0, dls: 2'd3,
              stop: 1'b0, pen: 1'b0, eps: 1'b0};
        @(negedge pClk);
        drive(c);
        TxStart = 1'b1;
        @(negedge pClk);
        TxStart = 1'b0;
        repeat (16 * 2 + 7) @(negedge pClk);
        tests++;
        if (Tx !== 1'b0 || TxBusy !== 1'b1) begin
            failed++;
            $display("FAIL pre_abort: tx=%b busy=%b, want 0 1", Tx, TxBusy);
        end
        #2 pReset = 1'b1;
        #1;
        tests++;
        if (Tx !== 1'b1 || TxBusy !== 1'b0 || TxDone !== 1'b0) begin
            failed++;
            $display("FAIL async_abort: tx=%b busy=%b done=%b, want 1 0 0",
                     Tx, TxBusy, TxDone);
        end
        bad = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge pClk);
            if (TxDone !== 1'b0 || Tx !== 1'b1 || TxBusy !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            failed++;
            $display("FAIL abort_hold: tx=%b busy=%b done=%b, want 1 0 0",
                     Tx, TxBusy, TxDone);
        end
        d = '{data: 8'hC7, ubrr: 12'd1, dls: 2'd2,
              stop: 1'b1, pen: 1'b1, eps: 1'b0};
        pReset = 1'b0;
        drive(d);
        TxStart = 1'b1;
        run_frame(d, model(d), 1'b1, 1'b0, 1'b0, d, "after_reset");
    endtask

    task automatic test_random();
        cfg_t c;
        cfg_t nx;
        bit st;
        bit ch;
        st = 1'b0;
        c = rand_cfg();
        for (int i = 0; i < 10; i++) begin
            nx = rand_cfg();
            ch = (i < 9) && ($urandom_range(0, 1) == 1);
            run_frame(c, model(c), st, 1'b0, ch, nx, "random");
            st = ch;
            c = nx;
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_parity();
        test_ignore_midframe();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
